// File: rtl/seg7_scan_display_pkg.sv
// Shared types, glyph constants and the double-dabble step for the 3-digit scanned 7-segment display.
package seg7_scan_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam int SEG7_DIGITS = 3;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0 = 7'h3F;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5B;
  localparam logic [6:0] SEG7_3 = 7'h4F;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6D;
  localparam logic [6:0] SEG7_6 = 7'h7D;
  localparam logic [6:0] SEG7_7 = 7'h07;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h6F;
  localparam logic [6:0] SEG7_A = 7'h77;
  localparam logic [6:0] SEG7_B = 7'h7C;
  localparam logic [6:0] SEG7_C = 7'h39;
  localparam logic [6:0] SEG7_D = 7'h5E;
  localparam logic [6:0] SEG7_E = 7'h79;
  localparam logic [6:0] SEG7_F = 7'h71;

  // One double-dabble iteration: add-3 on every nibble >= 5, then shift {bcd, bin} left by one.
  function automatic logic [19:0] dd_step(input logic [11:0] bcd, input logic [7:0] bin);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display bus: value in, scan tick in, segment/anode drive and conversion status out.
interface seg7_scan_display_if;
  import seg7_scan_display_pkg::*;

  // No backpressure: done pulses for one cycle in the cycle disp holds a freshly committed value.
  logic        tick;
  logic [7:0]  data;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        busy;
  logic        done;
  logic [11:0] disp;
  conv_state_t state;

  modport master (output tick, data, input seg, an, busy, done, disp, state);
  modport slave  (input tick, data, output seg, an, busy, done, disp, state);
endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to active-high 7-segment glyph decoder.
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG7_0;
    case (nibble)
      4'h0: glyph = SEG7_0;
      4'h1: glyph = SEG7_1;
      4'h2: glyph = SEG7_2;
      4'h3: glyph = SEG7_3;
      4'h4: glyph = SEG7_4;
      4'h5: glyph = SEG7_5;
      4'h6: glyph = SEG7_6;
      4'h7: glyph = SEG7_7;
      4'h8: glyph = SEG7_8;
      4'h9: glyph = SEG7_9;
      4'hA: glyph = SEG7_A;
      4'hB: glyph = SEG7_B;
      4'hC: glyph = SEG7_C;
      4'hD: glyph = SEG7_D;
      4'hE: glyph = SEG7_E;
      4'hF: glyph = SEG7_F;
      default: glyph = SEG7_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Converts an 8-bit value to BCD (or hex) and scans it onto a 3-digit multiplexed 7-segment display.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int BCD_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_display_if.slave    bus
);

  localparam bit         BCD     = (BCD_MODE != 0);
  localparam bit         ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam bit         BLANK   = (BLANK_LEADING != 0);
  localparam logic [6:0] SEG_OFF = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = ACT_LOW ? 3'b111 : 3'b000;
  localparam logic [1:0] IDX_MAX = 2'(SEG7_DIGITS - 1);

  conv_state_t state;
  logic [7:0]  src_reg;
  logic [11:0] bcd;
  logic [7:0]  bin;
  logic [2:0]  iter;
  logic [11:0] disp_reg;
  logic        busy;
  logic        done;

  // Conversion FSM; disp_reg is written only in COMMIT so the scan never sees a half-built value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      src_reg  <= 8'd0;
      bcd      <= 12'd0;
      bin      <= 8'd0;
      iter     <= 3'd0;
      disp_reg <= 12'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.data != src_reg) begin
            src_reg <= bus.data;
            bcd     <= 12'd0;
            bin     <= bus.data;
            iter    <= 3'd0;
            busy    <= 1'b1;
            state   <= BCD ? ST_SHIFT : ST_COMMIT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin} <= dd_step(bcd, bin);
          iter       <= iter + 3'd1;
          if (iter == 3'd7) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_reg <= BCD ? bcd : {4'h0, src_reg};
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // TICK is asynchronous: two synchroniser flops plus one edge-detect flop.
  logic [2:0] tick_sync;
  logic       scan_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_sync <= 3'b000;
    else     tick_sync <= {tick_sync[1:0], bus.tick};
  end

  assign scan_en = tick_sync[1] & ~tick_sync[2];

  logic [1:0] idx;
  logic [1:0] next_idx;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] glyph;
  logic [6:0] seg_q;
  logic [2:0] an_q;

  assign next_idx = (idx == IDX_MAX) ? 2'd0 : idx + 2'd1;

  always_comb begin
    digit = disp_reg[3:0];
    blank = 1'b0;
    case (next_idx)
      2'd1: begin
        digit = disp_reg[7:4];
        blank = BLANK && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
      end
      2'd2: begin
        digit = disp_reg[11:8];
        blank = !BCD || (BLANK && (disp_reg[11:8] == 4'd0));
      end
      default: begin
        digit = disp_reg[3:0];
        blank = 1'b0;
      end
    endcase
  end

  hex_to_seg7 u_glyph (
    .nibble (digit),
    .glyph  (glyph)
  );

  // Outputs follow the new index one cycle after scan_en and hold until the next scan step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 2'd0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else if (scan_en) begin
      idx <= next_idx;
      if (blank) begin
        seg_q <= SEG_OFF;
        an_q  <= AN_OFF;
      end else begin
        seg_q <= ACT_LOW ? ~glyph : glyph;
        an_q  <= ACT_LOW ? ~(3'b001 << next_idx) : (3'b001 << next_idx);
      end
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.disp  = disp_reg;
  assign bus.state = state;

endmodule
